// File: rtl/aer_pkg.sv
// Shared AER definitions: code/address widths, receiver FSM states and
// default handshake timing parameters.
package aer_pkg;

    localparam int unsigned AER_OH_WIDTH         = 16;
    localparam int unsigned AER_ADDR_WIDTH       = $clog2(AER_OH_WIDTH);
    localparam int unsigned AER_RST_PULSE_CYCLES = 4;
    localparam int unsigned AER_TIMEOUT_CYCLES   = 1023;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        PIXRST,
        ACK,
        RECOVER
    } aer_rx_state_t;

endpackage

// File: rtl/aer_oh_encoder.sv
// One-hot to binary encoder: index of the lowest set bit, plus flags for
// an all-zero code and for more than one bit set.
module aer_oh_encoder
    import aer_pkg::*;
#(
    parameter int unsigned OH_WIDTH   = AER_OH_WIDTH,
    parameter int unsigned ADDR_WIDTH = AER_ADDR_WIDTH
) (
    input  logic [OH_WIDTH-1:0]   code,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  multi_hot,
    output logic                  zero
);

    // Scan from the top so the lowest set bit is written last and wins.
    always_comb begin
        addr = '0;
        for (int unsigned i = OH_WIDTH; i > 0; i--) begin
            if (code[i-1]) begin
                addr = ADDR_WIDTH'(i - 1);
            end
        end
    end

    assign multi_hot = |(code & (code - OH_WIDTH'(1)));
    assign zero      = ~|code;

endmodule

// File: rtl/aer_rx_ctrl.sv
// AER receive-side handshake controller: synchronises the one-hot request,
// emits the encoded event on a valid/ready stream, pulses the pixel reset
// and completes the four-phase ack handshake with a release timeout.
module aer_rx_ctrl
    import aer_pkg::*;
#(
    parameter int unsigned OH_WIDTH         = AER_OH_WIDTH,
    parameter int unsigned ADDR_WIDTH       = AER_ADDR_WIDTH,
    parameter int unsigned RST_PULSE_CYCLES = AER_RST_PULSE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES   = AER_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [OH_WIDTH-1:0]   one_hot_code,
    output logic                  ack,
    output logic                  aer_rst_n,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [ADDR_WIDTH-1:0] evt_addr,
    output logic                  evt_err,
    output logic                  err_multi_hot,
    output logic                  err_timeout,
    input  logic                  clr_err
);

    localparam logic [15:0] PULSE_LAST   = 16'(RST_PULSE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [OH_WIDTH-1:0]   sync_q;
    logic [OH_WIDTH-1:0]   s;
    logic [OH_WIDTH-1:0]   s_d;
    logic [ADDR_WIDTH-1:0] enc_addr;
    logic                  enc_multi;
    logic                  s_zero;
    logic [15:0]           cnt;
    aer_rx_state_t         state;

    aer_oh_encoder #(
        .OH_WIDTH   (OH_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_enc (
        .code      (s),
        .addr      (enc_addr),
        .multi_hot (enc_multi),
        .zero      (s_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q        <= '0;
            s             <= '0;
            s_d           <= '0;
            state         <= IDLE;
            cnt           <= '0;
            ack           <= 1'b0;
            aer_rst_n     <= 1'b1;
            evt_valid     <= 1'b0;
            evt_addr      <= '0;
            evt_err       <= 1'b0;
            err_multi_hot <= 1'b0;
            err_timeout   <= 1'b0;
        end else begin
            sync_q <= one_hot_code;
            s      <= sync_q;
            s_d    <= s;

            // Clear first; a set later in this block overrides it.
            if (clr_err) begin
                err_multi_hot <= 1'b0;
                err_timeout   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (enable && !s_zero && (s == s_d)) begin
                        evt_addr  <= enc_addr;
                        evt_err   <= enc_multi;
                        evt_valid <= 1'b1;
                        if (enc_multi) begin
                            err_multi_hot <= 1'b1;
                        end
                        state <= PUSH;
                    end
                end
                PUSH: begin
                    if (evt_ready) begin
                        evt_valid <= 1'b0;
                        aer_rst_n <= 1'b0;
                        cnt       <= '0;
                        state     <= PIXRST;
                    end
                end
                PIXRST: begin
                    if (cnt == PULSE_LAST) begin
                        aer_rst_n <= 1'b1;
                        ack       <= 1'b1;
                        cnt       <= '0;
                        state     <= ACK;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ACK: begin
                    if (s_zero) begin
                        ack   <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        ack         <= 1'b0;
                        err_timeout <= 1'b1;
                        state       <= RECOVER;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                RECOVER: begin
                    if (s_zero) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aer_rx_ctrl.sv
// Scoreboard bench for aer_rx_ctrl: stimulus queues expected events from a
// bit-arithmetic model, a negedge monitor checks every accepted event.
module tb_aer_rx_ctrl;
    import aer_pkg::*;

    localparam int unsigned OHW   = 16;
    localparam int unsigned AW    = 4;
    localparam int unsigned PULSE = 4;
    localparam int unsigned TMO   = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [OHW-1:0] one_hot_code;
    logic           ack;
    logic           aer_rst_n;
    logic           evt_valid;
    logic           evt_ready;
    logic [AW-1:0]  evt_addr;
    logic           evt_err;
    logic           err_multi_hot;
    logic           err_timeout;
    logic           clr_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    aer_rx_ctrl #(
        .OH_WIDTH         (OHW),
        .ADDR_WIDTH       (AW),
        .RST_PULSE_CYCLES (PULSE),
        .TIMEOUT_CYCLES   (TMO)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .one_hot_code  (one_hot_code),
        .ack           (ack),
        .aer_rst_n     (aer_rst_n),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_addr      (evt_addr),
        .evt_err       (evt_err),
        .err_multi_hot (err_multi_hot),
        .err_timeout   (err_timeout),
        .clr_err       (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Lowest set bit isolated by two's complement, index by log2.
    function automatic exp_t model(input logic [OHW-1:0] code);
        exp_t           r;
        logic [OHW-1:0] low;
        low    = code & (~code + OHW'(1));
        r.addr = AW'($clog2(low));
        r.err  = ($countones(code) > 1);
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got addr %0d, expected no event", evt_addr);
            end else begin
                e = exp_q.pop_front();
                chk("evt_addr", 32'(evt_addr), 32'(e.addr));
                chk("evt_err", 32'(evt_err), 32'(e.err));
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a code, optionally stall the consumer, then check the pixel
    // reset pulse and the ack rise. Ends just after ack went high.
    task automatic run_event(input logic [OHW-1:0] code, input int delay);
        exp_t e;
        int   t;
        int   low;
        e            = model(code);
        evt_ready    = (delay == 0);
        one_hot_code = code;
        exp_q.push_back(e);
        t = 0;
        while (evt_valid !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        chk("evt_valid_rise", 32'(evt_valid), 32'd1);
        chk("no_ack_before_accept", 32'(ack), 32'd0);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("bp_valid_held", 32'(evt_valid), 32'd1);
            chk("bp_addr_held", 32'(evt_addr), 32'(e.addr));
            chk("bp_rst_n_high", 32'(aer_rst_n), 32'd1);
            chk("bp_ack_low", 32'(ack), 32'd0);
        end
        evt_ready = 1'b1;
        step();
        chk("pixrst_start", 32'(aer_rst_n), 32'd0);
        chk("valid_dropped", 32'(evt_valid), 32'd0);
        low = 0;
        while (aer_rst_n === 1'b0 && low < 300) begin
            low++;
            step();
        end
        chk("pixrst_len", 32'(low), 32'(PULSE));
        chk("ack_rise", 32'(ack), 32'd1);
    endtask

    // Release before the next edge k: ack stays up after k and k+1, low after k+2.
    task automatic release_code();
        one_hot_code = '0;
        step();
        chk("ack_hold_k", 32'(ack), 32'd1);
        step();
        chk("ack_hold_k1", 32'(ack), 32'd1);
        step();
        chk("ack_fall_k2", 32'(ack), 32'd0);
        step(2);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int             nv;
        int             hi;
        logic [OHW-1:0] a;
        logic [OHW-1:0] b;
        logic [OHW-1:0] c;

        rst          = 1'b1;
        enable       = 1'b1;
        one_hot_code = '0;
        evt_ready    = 1'b1;
        clr_err      = 1'b0;
        step(3);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_aer_rst_n", 32'(aer_rst_n), 32'd1);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_evt_addr", 32'(evt_addr), 32'd0);
        chk("rst_evt_err", 32'(evt_err), 32'd0);
        chk("rst_err_multi_hot", 32'(err_multi_hot), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        rst = 1'b0;
        step(2);

        run_event(16'h0020, 0);
        release_code();

        run_event(16'h8000, 10);
        release_code();

        run_event(16'h0110, 0);
        release_code();
        chk("multi_hot_sticky", 32'(err_multi_hot), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("multi_hot_cleared", 32'(err_multi_hot), 32'd0);

        run_event(16'h0004, 0);
        hi = 0;
        while (ack === 1'b1 && hi < 100) begin
            hi++;
            step();
        end
        chk("ack_timeout_len", 32'(hi), 32'(TMO));
        chk("err_timeout_set", 32'(err_timeout), 32'd1);
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (evt_valid === 1'b1) nv++;
        end
        chk("no_event_in_recover", 32'(nv), 32'd0);
        one_hot_code = '0;
        step(4);
        chk("recover_ack_low", 32'(ack), 32'd0);
        run_event(16'h0004, 0);
        release_code();
        chk("err_timeout_sticky", 32'(err_timeout), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("err_timeout_cleared", 32'(err_timeout), 32'd0);

        a = OHW'(1) << $urandom_range(0, OHW - 1);
        b = ~a & (OHW'($urandom) | (OHW'(1) << ($urandom_range(0, OHW - 1))));
        if (b == '0) b = {a[0], a[OHW-1:1]};
        nv = 0;
        for (int i = 0; i < 20; i++) begin
            one_hot_code = (i % 2 == 0) ? a : b;
            step();
            if (evt_valid === 1'b1) nv++;
        end
        one_hot_code = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (evt_valid === 1'b1) nv++;
        end
        chk("glitch_no_capture", 32'(nv), 32'd0);

        enable       = 1'b0;
        one_hot_code = 16'h0100;
        nv           = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (evt_valid === 1'b1) nv++;
        end
        chk("disabled_no_capture", 32'(nv), 32'd0);
        enable = 1'b1;
        run_event(16'h0100, 0);
        release_code();

        for (int n = 0; n < 10; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                c = OHW'($urandom) | (OHW'(1) << $urandom_range(0, OHW - 1));
            end else begin
                c = OHW'(1) << $urandom_range(0, OHW - 1);
            end
            run_event(c, int'($urandom_range(0, 5)));
            release_code();
        end

        evt_ready    = 1'b1;
        one_hot_code = 16'h0040;
        exp_q.push_back(model(16'h0040));
        hi = 0;
        while (evt_valid !== 1'b1 && hi < 20) begin
            step();
            hi++;
        end
        chk("mid_rst_valid", 32'(evt_valid), 32'd1);
        step();
        chk("mid_rst_pixrst", 32'(aer_rst_n), 32'd0);
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_aer_rst_n", 32'(aer_rst_n), 32'd1);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("mid_rst_state", 32'(u_dut.state), 32'(IDLE));
        one_hot_code = '0;
        step(3);
        rst = 1'b0;
        step(5);
        chk("post_rst_idle_valid", 32'(evt_valid), 32'd0);
        chk("post_rst_idle_ack", 32'(ack), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
